key_onehot_capture: RTL and testbench
=====================================

// Module: key_onehot_capture
// PURPOSE
//  Front end for the 8-to-3 encoder stage. Samples 8 raw key/switch lines,
//  synchronises and debounces them, accepts a press only when exactly one
//  key is down, and latches it as a one-hot byte on oData. oData feeds the
//  encoder's iData directly. It is never zero or multi-hot, so the encoder
//  always sees a legal code.
// PARAMETERS
//  STABLE_CYCLES  16  consecutive cycles a synchronised key vector must stay unchanged to count as debounced (>=2)
// PORTS
//  clk     in   1  system clock, all state on rising edge
//  rst     in   1  asynchronous, active-high reset
//  iKey    in   8  raw key lines, active-high, asynchronous to clk, may bounce
//  oData   out  8  last accepted one-hot key code (to encoder iData)
//  oValid  out  1  one-cycle pulse: new single-key press accepted this cycle
//  oBusy   out  1  high while any debounced key is down (state != IDLE)
//  oErr    out  1  high while a multi-key press is being rejected
// BEHAVIOUR
//  Reset (async, immediate): oData=8'h01, oValid=0, oBusy=0, oErr=0.
//   Sync flops, key_last, key_db and cnt are 0; FSM goes to IDLE.
//  Sync: 2-flop synchroniser per bit, iKey -> s1 -> s2.
//  Debounce: key_last <= s2 every cycle.
//   cnt <= (s2 != key_last) ? 0 : min(cnt+1, STABLE_CYCLES-1).
//   key_db <= key_last whenever cnt == STABLE_CYCLES-1.
//   A change shorter than STABLE_CYCLES cycles never reaches key_db.
//   cnt width is $clog2(STABLE_CYCLES)+1.
//  FSM (registered; oValid, oErr and oData are registered outputs):
//   IDLE:    key_db==0 -> stay.
//            key_db one-hot -> oData<=key_db, oValid<=1 for 1 cycle, go PRESSED.
//            key_db has >=2 bits -> oErr<=1, go ERROR; oData unchanged.
//   PRESSED: key_db==0 -> IDLE. Any nonzero key_db -> stay.
//            Rollover and added keys are ignored: no oValid, no oErr.
//   ERROR:   oErr held high. key_db==0 -> oErr<=0, go IDLE.
//  oBusy = (state != IDLE).
//  Latency: count the first clk edge that samples a new stable iKey value as
//   edge 1. key_db updates on edge STABLE_CYCLES+3. oValid is high for
//   exactly one cycle following edge STABLE_CYCLES+4. Release is seen
//   (oBusy falls) on that same edge count after iKey returns to 0.
//  Near-simultaneous keys: if a second key arrives before the first is
//   debounced, cnt restarts and key_db sees both keys -> ERROR.
//   If the second key arrives after acceptance -> ignored (PRESSED).
//  oData holds its value across release, error and idle. It changes only on
//   an accepted press or on reset.
//  Reset mid-press: outputs clear at once. If a key is still held when rst
//   deasserts, it is treated as a fresh press (oValid after STABLE_CYCLES+4
//   edges).
// TESTING  (bench uses STABLE_CYCLES=4; edge 1 = first edge sampling new iKey)
//  1. Assert rst for 3 cycles, iKey=0 -> oData=8'h01, oValid=oBusy=oErr=0;
//     encoder output 3'b000.
//  2. iKey=8'h20 held 20 cycles -> oValid high for exactly one cycle after
//     edge 8; then oData=8'h20, oBusy=1, encoder output 3'b101. Set iKey=0 ->
//     oBusy falls after edge 8; oData stays 8'h20.
//  3. Bounce: iKey toggles 8'h00/8'h08 every 2 cycles for 12 cycles, then 0
//     -> no oValid, oBusy stays 0, oData unchanged.
//  4. iKey=8'h41 held -> oErr=1 after edge 8, no oValid, oData unchanged.
//     iKey=0 -> oErr=0 and oBusy=0 after edge 8.
//  5. Press 8'h02 (accepted), then change iKey to 8'h82 -> no oValid, no oErr,
//     oData=8'h02. Release all, then press 8'h80 -> one oValid,
//     oData=8'h80, encoder output 3'b111.
//  6. Hold 8'h10 until accepted, pulse rst mid-press with key still held ->
//     outputs reset immediately. After rst falls: oValid after edge 8,
//     oData=8'h10.

Source files
------------

// File: rtl/key_onehot_capture.sv
// rtl/key_onehot_capture.sv - synchronise, debounce and one-hot capture of 8 key lines
module key_onehot_capture #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] iKey,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oBusy,
    output logic       oErr
);

    localparam int            CW      = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_ERROR
    } state_t;

    logic [7:0]    s1;
    logic [7:0]    s2;
    logic [7:0]    key_last;
    logic [7:0]    key_db;
    logic [CW-1:0] cnt;

    state_t     state;
    state_t     state_d;
    logic [7:0] data_d;
    logic       valid_d;
    logic       err_d;

    logic db_zero;
    logic db_onehot;

    // Two-flop synchroniser; iKey is asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 8'h00;
            s2 <= 8'h00;
        end else begin
            s1 <= iKey;
            s2 <= s1;
        end
    end

    // cnt saturates at CNT_MAX, so key_db keeps tracking a vector that stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_last <= 8'h00;
            key_db   <= 8'h00;
            cnt      <= '0;
        end else begin
            key_last <= s2;
            if (s2 != key_last) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == CNT_MAX) begin
                key_db <= key_last;
            end
        end
    end

    assign db_zero   = (key_db == 8'h00);
    assign db_onehot = !db_zero && ((key_db & (key_db - 8'h01)) == 8'h00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            oData  <= 8'h01;
            oValid <= 1'b0;
            oErr   <= 1'b0;
        end else begin
            state  <= state_d;
            oData  <= data_d;
            oValid <= valid_d;
            oErr   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        data_d  = oData;
        valid_d = 1'b0;
        err_d   = oErr;
        case (state)
            ST_IDLE: begin
                if (db_onehot) begin
                    data_d  = key_db;
                    valid_d = 1'b1;
                    state_d = ST_PRESSED;
                end else if (!db_zero) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end
            end
            ST_PRESSED: begin
                // Rollover or extra keys while held are deliberately ignored.
                if (db_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                err_d = 1'b1;
                if (db_zero) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    assign oBusy = (state != ST_IDLE);

endmodule

// File: tb/tb_key_onehot_capture.sv
// tb/tb_key_onehot_capture.sv - directed bench for key_onehot_capture with STABLE_CYCLES=4
module tb_key_onehot_capture;

    logic       clk;
    logic       rst;
    logic [7:0] iKey;
    logic [7:0] oData;
    logic       oValid;
    logic       oBusy;
    logic       oErr;

    int tests_run = 0;
    int tests_failed = 0;

    int vcnt, vfirst, bfirst, efirst;
    int bounce_valid, bounce_busy;

    key_onehot_capture #(.STABLE_CYCLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .iKey   (iKey),
        .oData  (oData),
        .oValid (oValid),
        .oBusy  (oBusy),
        .oErr   (oErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] enc(input logic [7:0] b);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Apply k (called #1 after a rising edge), run n edges and record when things change.
    task automatic press(input logic [7:0] k, input int n,
                         output int vc, output int vf, output int bf, output int ef);
        logic b0, e0;
        b0 = oBusy;
        e0 = oErr;
        vc = 0; vf = -1; bf = -1; ef = -1;
        iKey = k;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            if (oValid) begin
                vc++;
                if (vf < 0) vf = e;
            end
            if (bf < 0 && oBusy !== b0) bf = e;
            if (ef < 0 && oErr !== e0) ef = e;
        end
    endtask

    initial begin
        rst  = 1'b1;
        iKey = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", oData, 8'h01);
        check("rst_valid", oValid, 1'b0);
        check("rst_busy", oBusy, 1'b0);
        check("rst_err", oErr, 1'b0);
        check("rst_enc", enc(oData), 3'b000);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single press and release
        press(8'h20, 20, vcnt, vfirst, bfirst, efirst);
        check("p20_vcnt", vcnt, 1);
        check("p20_vedge", vfirst, 8);
        check("p20_data", oData, 8'h20);
        check("p20_busy", oBusy, 1'b1);
        check("p20_enc", enc(oData), 3'b101);
        press(8'h00, 20, vcnt, vfirst, bfirst, efirst);
        check("r20_busy_edge", bfirst, 8);
        check("r20_vcnt", vcnt, 0);
        check("r20_data", oData, 8'h20);

        // Bounce shorter than the debounce window
        bounce_valid = 0;
        bounce_busy  = 0;
        for (int i = 0; i < 12; i++) begin
            iKey = (i % 4 < 2) ? 8'h08 : 8'h00;
            @(posedge clk);
            #1;
            if (oValid) bounce_valid++;
            if (oBusy) bounce_busy++;
        end
        iKey = 8'h00;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (oValid) bounce_valid++;
            if (oBusy) bounce_busy++;
        end
        check("bounce_valid", bounce_valid, 0);
        check("bounce_busy", bounce_busy, 0);
        check("bounce_data", oData, 8'h20);

        // Multi-key rejection
        press(8'h41, 20, vcnt, vfirst, bfirst, efirst);
        check("m41_err_edge", efirst, 8);
        check("m41_err", oErr, 1'b1);
        check("m41_vcnt", vcnt, 0);
        check("m41_data", oData, 8'h20);
        press(8'h00, 20, vcnt, vfirst, bfirst, efirst);
        check("r41_err_edge", efirst, 8);
        check("r41_busy_edge", bfirst, 8);
        check("r41_err", oErr, 1'b0);
        check("r41_busy", oBusy, 1'b0);

        // Rollover after acceptance is ignored
        press(8'h02, 20, vcnt, vfirst, bfirst, efirst);
        check("p02_vcnt", vcnt, 1);
        check("p02_data", oData, 8'h02);
        press(8'h82, 20, vcnt, vfirst, bfirst, efirst);
        check("p82_vcnt", vcnt, 0);
        check("p82_err_edge", efirst, -1);
        check("p82_data", oData, 8'h02);
        press(8'h00, 20, vcnt, vfirst, bfirst, efirst);
        check("r82_busy", oBusy, 1'b0);
        press(8'h80, 20, vcnt, vfirst, bfirst, efirst);
        check("p80_vcnt", vcnt, 1);
        check("p80_data", oData, 8'h80);
        check("p80_enc", enc(oData), 3'b111);
        press(8'h00, 20, vcnt, vfirst, bfirst, efirst);

        // Reset mid-press with the key still held
        press(8'h10, 20, vcnt, vfirst, bfirst, efirst);
        check("p10_vcnt", vcnt, 1);
        check("p10_data", oData, 8'h10);
        rst = 1'b1;
        #1;
        check("mrst_data", oData, 8'h01);
        check("mrst_busy", oBusy, 1'b0);
        check("mrst_valid", oValid, 1'b0);
        check("mrst_err", oErr, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        press(8'h10, 20, vcnt, vfirst, bfirst, efirst);
        check("prst_vedge", vfirst, 8);
        check("prst_vcnt", vcnt, 1);
        check("prst_data", oData, 8'h10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
